// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - button inputs, enable and press pulses of the key conditioner
interface key_conditioner_if;
  logic       en;
  logic       up_in;
  logic       down_in;
  logic       left_in;
  logic       right_in;
  logic       s_in;
  logic       up_p;
  logic       down_p;
  logic       left_p;
  logic       right_p;
  logic       s_p;
  logic [4:0] keys_lvl;

  modport master (
    output en, up_in, down_in, left_in, right_in, s_in,
    input  up_p, down_p, left_p, right_p, s_p, keys_lvl
  );

  modport slave (
    input  en, up_in, down_in, left_in, right_in, s_in,
    output up_p, down_p, left_p, right_p, s_p, keys_lvl
  );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - sync, debounce, edge-detect and auto-repeat for five push-buttons
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 15000000,
  parameter int CNT_W           = 26
) (
  input  logic             clk,
  input  logic             rst,
  key_conditioner_if.slave kif
);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT, BLOCK} dir_state_t;

  // Bit order everywhere: {up, down, left, right, s}
  logic [4:0]       raw;
  logic [4:0]       meta;
  logic [4:0]       sync;
  logic [4:0]       stable;
  logic [4:0]       stable_d;
  logic [CNT_W-1:0] db_cnt [5];

  logic [3:0]       dir_rise;
  logic [3:0]       dir_fall;
  logic             s_rise;
  logic [3:0]       req;
  logic [3:0]       grant;
  dir_state_t       state [4];
  logic [CNT_W-1:0] rcnt  [4];

  assign raw = {kif.up_in, kif.down_in, kif.left_in, kif.right_in, kif.s_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= '0;
      stable_d <= '0;
      for (int k = 0; k < 5; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      stable_d <= stable;
      for (int k = 0; k < 5; k++) begin
        if (sync[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          stable[k] <= sync[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_ONE;
        end
      end
    end
  end

  assign kif.keys_lvl = stable;
  assign dir_rise     = stable[4:1] & ~stable_d[4:1];
  assign dir_fall     = ~stable[4:1] & stable_d[4:1];
  assign s_rise       = stable[0] & ~stable_d[0];

  // Index 3 = up ... 0 = right; a pulse request is what the FSM would emit this cycle
  always_comb begin
    req = '0;
    for (int i = 0; i < 4; i++) begin
      case (state[i])
        IDLE:    req[i] = dir_rise[i] & kif.en;
        HOLD:    req[i] = ~dir_fall[i] & kif.en & (rcnt[i] == DLY_LAST);
        RPT:     req[i] = ~dir_fall[i] & kif.en & (rcnt[i] == RATE_LAST);
        default: req[i] = 1'b0;
      endcase
    end
  end

  // Lower-priority requests are dropped, not deferred
  assign grant[3] = req[3];
  assign grant[2] = req[2] & ~req[3];
  assign grant[1] = req[1] & ~(|req[3:2]);
  assign grant[0] = req[0] & ~(|req[3:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        rcnt[i]  <= '0;
      end
      kif.up_p    <= 1'b0;
      kif.down_p  <= 1'b0;
      kif.left_p  <= 1'b0;
      kif.right_p <= 1'b0;
      kif.s_p     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (state[i])
          IDLE: begin
            if (dir_rise[i]) begin
              rcnt[i]  <= '0;
              state[i] <= kif.en ? HOLD : BLOCK;
            end
          end
          HOLD: begin
            if (dir_fall[i]) begin
              state[i] <= IDLE;
            end else if (!kif.en) begin
              state[i] <= BLOCK;
            end else if (rcnt[i] == DLY_LAST) begin
              rcnt[i]  <= '0;
              state[i] <= RPT;
            end else begin
              rcnt[i] <= rcnt[i] + CNT_ONE;
            end
          end
          RPT: begin
            if (dir_fall[i]) begin
              state[i] <= IDLE;
            end else if (!kif.en) begin
              state[i] <= BLOCK;
            end else if (rcnt[i] == RATE_LAST) begin
              rcnt[i] <= '0;
            end else begin
              rcnt[i] <= rcnt[i] + CNT_ONE;
            end
          end
          default: begin
            // Held key stays blocked until it is released, even if en returns
            if (dir_fall[i]) begin
              state[i] <= IDLE;
            end
          end
        endcase
      end
      kif.up_p    <= grant[3];
      kif.down_p  <= grant[2];
      kif.left_p  <= grant[1];
      kif.right_p <= grant[0];
      kif.s_p     <= s_rise & kif.en;
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner
module tb_key_conditioner;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raw;
  logic       en;
  logic [4:0] pulses;

  always #5 clk = ~clk;

  key_conditioner_if kif ();

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (26)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  assign kif.en       = en;
  assign kif.up_in    = raw[4];
  assign kif.down_in  = raw[3];
  assign kif.left_in  = raw[2];
  assign kif.right_in = raw[1];
  assign kif.s_in     = raw[0];
  assign pulses = {kif.up_p, kif.down_p, kif.left_p, kif.right_p, kif.s_p};

  int n_cmp = 0;
  int n_bad = 0;
  int cnt  [5];
  int base [5];

  // Reference model: debounced level = last D synced samples all opposite to it;
  // repeats are scheduled by elapsed time since the accepted press.
  logic [4:0] m_meta, m_sync, m_stable, m_stable_d, exp_p;
  logic [4:0] m_hist [D];
  int         m_mode [4];
  int         m_tact [4];
  int         m_e;

  task automatic model_step();
    logic [4:0] rise, fall, nstable;
    logic [3:0] want;
    logic       taken, all_opp;
    int         d, b;
    if (rst) begin
      m_meta = '0; m_sync = '0; m_stable = '0; m_stable_d = '0; exp_p = '0; m_e = 0;
      for (int j = 0; j < D; j++) m_hist[j] = '0;
      for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_tact[i] = 0; end
      return;
    end
    rise = m_stable & ~m_stable_d;
    fall = ~m_stable & m_stable_d;
    want = '0;
    for (int i = 0; i < 4; i++) begin
      b = 4 - i;
      if (fall[b]) m_mode[i] = 0;
      else if (m_mode[i] == 0) begin
        if (rise[b]) begin
          if (en) begin m_mode[i] = 1; m_tact[i] = m_e; want[i] = 1'b1; end
          else m_mode[i] = 2;
        end
      end else if (m_mode[i] == 1) begin
        if (!en) m_mode[i] = 2;
        else begin
          d = m_e - m_tact[i];
          if (d == RD || (d > RD && (d - RD) % RR == 0)) want[i] = 1'b1;
        end
      end
    end
    exp_p = '0;
    taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (want[i] && !taken) begin exp_p[4-i] = 1'b1; taken = 1'b1; end
    end
    exp_p[0] = rise[0] & en;
    for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = m_sync;
    nstable = m_stable;
    for (int k = 0; k < 5; k++) begin
      all_opp = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[j][k] == m_stable[k]) all_opp = 1'b0;
      if (all_opp) nstable[k] = ~m_stable[k];
    end
    m_stable_d = m_stable;
    m_stable   = nstable;
    m_sync     = m_meta;
    m_meta     = raw;
    m_e++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    n_cmp++;
    if ({pulses, kif.keys_lvl} !== {exp_p, m_stable}) begin
      n_bad++;
      $display("FAIL model t=%0t got p=%b lvl=%b want p=%b lvl=%b",
               $time, pulses, kif.keys_lvl, exp_p, m_stable);
    end
    for (int k = 0; k < 5; k++) if (pulses[k]) cnt[k]++;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  typedef struct packed {
    logic [4:0]       keys;
    logic             en;
    logic [7:0]       hold;
    logic [4:0][3:0]  exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int first, lvl_bad;
    logic [5:0] bounce;

    vecs[0] = '{keys: 5'b10000, en: 1'b1, hold: 8'd10,  exp: {4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[1] = '{keys: 5'b00010, en: 1'b1, hold: 8'd60,  exp: {4'd0, 4'd0, 4'd0, 4'd6, 4'd0}};
    vecs[2] = '{keys: 5'b00001, en: 1'b1, hold: 8'd100, exp: {4'd0, 4'd0, 4'd0, 4'd0, 4'd1}};
    vecs[3] = '{keys: 5'b11000, en: 1'b1, hold: 8'd30,  exp: {4'd3, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[4] = '{keys: 5'b00100, en: 1'b0, hold: 8'd20,  exp: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[5] = '{keys: 5'b01000, en: 1'b1, hold: 8'd2,   exp: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[6] = '{keys: 5'b00101, en: 1'b1, hold: 8'd27,  exp: {4'd0, 4'd0, 4'd2, 4'd0, 4'd1}};
    vecs[7] = '{keys: 5'b01010, en: 1'b1, hold: 8'd40,  exp: {4'd0, 4'd4, 4'd0, 4'd0, 4'd0}};

    for (int k = 0; k < 5; k++) cnt[k] = 0;
    rst = 1'b1; raw = '0; en = 1'b1;
    repeat (3) tick();
    check("reset_state", int'({pulses, kif.keys_lvl}), 0);
    rst = 1'b0;
    repeat (5) tick();

    for (int v = 0; v < 8; v++) begin
      base = cnt;
      en  = vecs[v].en;
      raw = vecs[v].keys;
      repeat (int'(vecs[v].hold)) tick();
      raw = '0;
      repeat (14) tick();
      en = 1'b1;
      for (int k = 0; k < 5; k++)
        check($sformatf("vec%0d_cnt%0d", v, k), cnt[k] - base[k], int'(vecs[v].exp[k]));
    end

    // Reset while up is repeating, then recover with up still held
    raw = 5'b10000;
    repeat (40) tick();
    rst = 1'b1;
    #1;
    check("rst_async", int'({pulses, kif.keys_lvl}), 0);
    repeat (2) tick();
    rst = 1'b0;
    base = cnt; first = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (kif.up_p && first == 0) first = t;
    end
    check("rst_first_up", first, 7);
    check("rst_up_cnt", cnt[4] - base[4], 1);
    raw = '0;
    repeat (14) tick();

    // Bounce 1,1,0,0,1,1 then steady high
    bounce = 6'b110011;
    base = cnt; first = 0;
    for (int t = 1; t <= 15; t++) begin
      raw[4] = (t <= 6) ? bounce[6-t] : 1'b1;
      tick();
      if (kif.up_p && first == 0) first = t;
    end
    check("bounce_first_up", first, 11);
    check("bounce_up_cnt", cnt[4] - base[4], 1);
    raw = '0;
    repeat (14) tick();

    // Select held 100 cycles
    raw = 5'b00001;
    base = cnt; lvl_bad = 0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (t >= 6 && kif.keys_lvl[0] !== 1'b1) lvl_bad++;
    end
    check("s_lvl_hold", lvl_bad, 0);
    check("s_cnt", cnt[0] - base[0], 1);
    raw = '0;
    repeat (6) tick();
    check("s_lvl_release", int'(kif.keys_lvl[0]), 0);
    repeat (8) tick();

    // Enable gate
    base = cnt;
    en = 1'b0; raw = 5'b00100;
    repeat (15) tick();
    en = 1'b1;
    repeat (30) tick();
    check("gate_held", cnt[2] - base[2], 0);
    raw = '0;
    repeat (14) tick();
    raw = 5'b00100;
    repeat (10) tick();
    check("gate_repress", cnt[2] - base[2], 1);
    raw = '0;
    repeat (14) tick();

    // Random traffic against the model
    for (int t = 0; t < 3000; t++) begin
      for (int k = 1; k < 5; k++) if ($urandom_range(0, 39) == 0) raw[k] = ~raw[k];
      if ($urandom_range(0, 15) == 0) raw[0] = ~raw[0];
      if ($urandom_range(0, 199) == 0) en = ~en;
      tick();
    end
    raw = '0; en = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
